lift_dispatcher: RTL and testbench

Hall-call dispatcher for a two-car lift bank. It latches floor hall calls into a pending register and picks one pending call at a time, round-robin. It assigns that call to the cheaper available car and delivers it to that car's lift controller over a valid/ready handshake. It sits between the hall call buttons and the per-car controllers and is the only source of car assignments.

---
 rtl/lift_pkg.sv | 22 ++
 rtl/lift_cost_calc.sv | 31 +++
 rtl/lift_dispatcher.sv | 189 ++++++++++++++++++
 tb/tb_lift_dispatcher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// lift_pkg: shared constants, floor type and dispatch state encoding for
// the two-car hall-call dispatcher.
package lift_pkg;

   localparam int N_FLOORS = 8;
   localparam int FLOOR_W  = 3;

   // Cost scale: floor distance plus a penalty for a car heading away.
   localparam int                COST_W       = 4;
   localparam logic [COST_W-1:0] COST_AWAY    = 4'd8;
   localparam logic [COST_W-1:0] COST_UNAVAIL = 4'd15;

   typedef logic [FLOOR_W-1:0] floor_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_EVAL,
      ST_OFFER
   } dispatch_state_t;

endpackage

// File: rtl/lift_cost_calc.sv
// lift_cost_calc: combinational cost of sending one car to a target floor.
// Cost is the floor distance, plus a penalty when the car is travelling
// away from the target; an unavailable car reports the maximum cost.
module lift_cost_calc
   import lift_pkg::*;
(
   input  logic [FLOOR_W-1:0] i_car_floor,
   input  logic               i_car_up,
   input  logic               i_car_down,
   input  logic               i_car_avail,
   input  logic [FLOOR_W-1:0] i_target,
   output logic [COST_W-1:0]  o_cost
);

   floor_t w_dist;
   logic   w_away;

   // Distance, direction penalty and availability override.
   always_comb begin
      w_dist = (i_car_floor >= i_target) ? (i_car_floor - i_target)
                                         : (i_target - i_car_floor);
      w_away = (i_car_up   && (i_target < i_car_floor)) ||
               (i_car_down && (i_target > i_car_floor));
      if (!i_car_avail) begin
         o_cost = COST_UNAVAIL;
      end else begin
         o_cost = COST_W'(w_dist) + (w_away ? COST_AWAY : '0);
      end
   end

endmodule

// File: rtl/lift_dispatcher.sv
// lift_dispatcher: hall-call dispatcher for a two-car lift bank.
// Latches hall calls into a pending register, picks one pending floor at a
// time round-robin, assigns it to the cheaper available car and offers it
// over a valid/ready handshake.
// Build option: define DISPATCH_AGING_EN to add a 4-bit age counter per
// floor; a pending floor whose age has saturated overrides the round-robin
// pick (lowest such floor first).
module lift_dispatcher #(
   parameter int N_FLOORS = lift_pkg::N_FLOORS,
   parameter int FLOOR_W  = lift_pkg::FLOOR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   call_valid,
   input  logic [FLOOR_W-1:0]     call_floor,
   input  logic [2*FLOOR_W-1:0]   car_floor,
   input  logic [1:0]             car_up,
   input  logic [1:0]             car_down,
   input  logic [1:0]             car_avail,
   output logic [1:0]             assign_valid,
   output logic [2*FLOOR_W-1:0]   assign_floor,
   input  logic [1:0]             assign_ready,
   output logic [N_FLOORS-1:0]    pending
);
   import lift_pkg::*;

   localparam int IDX_W = FLOOR_W + 1;

   dispatch_state_t             r_state, w_state_next;
   logic [N_FLOORS-1:0]         r_pending, w_pending_next;
   logic [N_FLOORS-1:0]         w_set_mask, w_clr_mask;
   logic [FLOOR_W-1:0]          r_target, w_target_next;
   logic [FLOOR_W-1:0]          r_rr_ptr, w_rr_ptr_next;
   logic                        r_sel, w_sel_next;
   logic [1:0]                  r_assign_valid, w_assign_valid_next;
   logic [2*FLOOR_W-1:0]        r_assign_floor, w_assign_floor_next;
   logic [FLOOR_W-1:0]          w_rr_floor, w_scan_floor, w_target_inc;
   logic [IDX_W-1:0]            w_rr_idx;
   logic [1:0][COST_W-1:0]      w_cost;
   logic                        w_hs, w_pick;

   // One cost calculator per car, both evaluating the latched target.
   for (genvar gi = 0; gi < 2; gi++) begin : g_cost
      lift_cost_calc u_cost (
         .i_car_floor (car_floor[gi*FLOOR_W +: FLOOR_W]),
         .i_car_up    (car_up[gi]),
         .i_car_down  (car_down[gi]),
         .i_car_avail (car_avail[gi]),
         .i_target    (r_target),
         .o_cost      (w_cost[gi])
      );
   end

   assign w_hs         = |(r_assign_valid & assign_ready);
   assign w_target_inc = (r_target == FLOOR_W'(N_FLOORS - 1)) ? '0 : r_target + 1'b1;
   // Car 1 only when car 0 is out, or both are in and car 1 is strictly cheaper.
   assign w_pick       = !car_avail[0] | (car_avail[1] & (w_cost[1] < w_cost[0]));

   // Pending update: a new call sets its bit and beats a same-cycle clear.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (call_valid) w_set_mask[call_floor] = 1'b1;
      if (w_hs)       w_clr_mask[r_target]   = 1'b1;
      w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;
   end

   // Round-robin pick: first pending floor at or above r_rr_ptr, wrapping.
   always_comb begin
      w_rr_floor = r_rr_ptr;
      w_rr_idx   = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         w_rr_idx = {1'b0, r_rr_ptr} + IDX_W'(i);
         if (w_rr_idx >= IDX_W'(N_FLOORS)) w_rr_idx = w_rr_idx - IDX_W'(N_FLOORS);
         if (r_pending[w_rr_idx[FLOOR_W-1:0]]) w_rr_floor = w_rr_idx[FLOOR_W-1:0];
      end
   end

`ifdef DISPATCH_AGING_EN
   localparam logic [3:0] AGE_MAX = 4'd15;

   logic [N_FLOORS-1:0][3:0] r_age, w_age_next;
   logic                     w_age_hit;
   logic [FLOOR_W-1:0]       w_age_floor;

   for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_age
      assign w_age_next[gi] = !r_pending[gi]          ? 4'd0 :
                              (r_age[gi] == AGE_MAX)  ? AGE_MAX : r_age[gi] + 4'd1;
   end

   // Age counters: count while pending, saturate, clear when not pending.
   always_ff @(posedge clk) begin
      if (reset) r_age <= '0;
      else       r_age <= w_age_next;
   end

   // Lowest floor that is still pending and has a saturated age.
   always_comb begin
      w_age_hit   = 1'b0;
      w_age_floor = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (r_pending[i] && (r_age[i] == AGE_MAX)) begin
            w_age_hit   = 1'b1;
            w_age_floor = FLOOR_W'(i);
         end
      end
   end

   assign w_scan_floor = w_age_hit ? w_age_floor : w_rr_floor;
`else
   assign w_scan_floor = w_rr_floor;
`endif

   // Dispatch FSM next state and registered-output next values.
   always_comb begin
      w_state_next        = r_state;
      w_target_next       = r_target;
      w_rr_ptr_next       = r_rr_ptr;
      w_sel_next          = r_sel;
      w_assign_valid_next = r_assign_valid;
      w_assign_floor_next = r_assign_floor;
      case (r_state)
         ST_IDLE: begin
            if ((r_pending != '0) || call_valid) w_state_next = ST_SCAN;
         end
         ST_SCAN: begin
            if (r_pending == '0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_target_next = w_scan_floor;
               w_state_next  = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (car_avail == 2'b00) begin
               // Nobody can take it: move past it and keep it pending.
               w_rr_ptr_next = w_target_inc;
               w_state_next  = ST_SCAN;
            end else begin
               w_sel_next          = w_pick;
               w_assign_valid_next = {w_pick, ~w_pick};
               w_assign_floor_next = w_pick ? {r_target, {FLOOR_W{1'b0}}}
                                            : {{FLOOR_W{1'b0}}, r_target};
               w_state_next        = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (w_hs) begin
               w_rr_ptr_next       = w_target_inc;
               w_assign_valid_next = '0;
               w_assign_floor_next = '0;
               w_state_next        = ST_SCAN;
            end else if (!car_avail[r_sel]) begin
               // Car withdrew before accepting: retract, call stays pending.
               w_assign_valid_next = '0;
               w_assign_floor_next = '0;
               w_state_next        = ST_SCAN;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State, pending and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_pending      <= '0;
         r_target       <= '0;
         r_rr_ptr       <= '0;
         r_sel          <= 1'b0;
         r_assign_valid <= '0;
         r_assign_floor <= '0;
      end else begin
         r_state        <= w_state_next;
         r_pending      <= w_pending_next;
         r_target       <= w_target_next;
         r_rr_ptr       <= w_rr_ptr_next;
         r_sel          <= w_sel_next;
         r_assign_valid <= w_assign_valid_next;
         r_assign_floor <= w_assign_floor_next;
      end
   end

   assign assign_valid = r_assign_valid;
   assign assign_floor = r_assign_floor;
   assign pending      = r_pending;

endmodule

// File: tb/tb_lift_dispatcher.sv
// tb_lift_dispatcher: directed scenarios plus randomized traffic for
// lift_dispatcher, checked every cycle against a behavioural model.
module tb_lift_dispatcher;

   localparam int NF = 8;
   localparam int FW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          call_valid;
   logic [FW-1:0] call_floor;
   logic [2*FW-1:0] car_floor;
   logic [1:0]    car_up, car_down, car_avail;
   logic [1:0]    assign_valid;
   logic [2*FW-1:0] assign_floor;
   logic [1:0]    assign_ready;
   logic [NF-1:0] pending;

   always #5 clk = ~clk;

   lift_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .call_valid   (call_valid),
      .call_floor   (call_floor),
      .car_floor    (car_floor),
      .car_up       (car_up),
      .car_down     (car_down),
      .car_avail    (car_avail),
      .assign_valid (assign_valid),
      .assign_floor (assign_floor),
      .assign_ready (assign_ready),
      .pending      (pending)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   localparam int PH_IDLE = 0, PH_SCAN = 1, PH_EVAL = 2, PH_OFFER = 3;

   bit m_pend[NF];
   bit m_old[NF];
   int m_ptr, m_phase, m_target, m_car;
`ifdef DISPATCH_AGING_EN
   int m_age[NF];
   int m_old_age[NF];
`endif

   function automatic void model_reset();
      foreach (m_pend[f]) m_pend[f] = 1'b0;
`ifdef DISPATCH_AGING_EN
      foreach (m_age[f]) m_age[f] = 0;
`endif
      m_ptr = 0; m_phase = PH_IDLE; m_target = 0; m_car = -1;
   endfunction

   function automatic int m_cost(input int c, input int t);
      int cf, d;
      cf = int'((car_floor >> (FW * c)) & 6'h7);
      d  = (cf > t) ? cf - t : t - cf;
      if ((car_up[c] && t < cf) || (car_down[c] && t > cf)) d += 8;
      return d;
   endfunction

   function automatic int m_pick();
`ifdef DISPATCH_AGING_EN
      for (int f = 0; f < NF; f++) if (m_old[f] && m_old_age[f] == 15) return f;
`endif
      for (int k = 0; k < NF; k++) if (m_old[(m_ptr + k) % NF]) return (m_ptr + k) % NF;
      return m_ptr;
   endfunction

   function automatic void model_step();
      bit any, hs;
      int c0, c1;
      if (reset) begin
         model_reset();
         return;
      end
      m_old = m_pend;
      any = 1'b0;
      foreach (m_old[f]) if (m_old[f]) any = 1'b1;
      hs = (m_car >= 0) && assign_ready[m_car];
      if (hs) m_pend[m_target] = 1'b0;
      if (call_valid) m_pend[call_floor] = 1'b1;
`ifdef DISPATCH_AGING_EN
      m_old_age = m_age;
      foreach (m_age[f]) m_age[f] = m_old[f] ? ((m_old_age[f] < 15) ? m_old_age[f] + 1 : 15) : 0;
`endif
      case (m_phase)
         PH_IDLE: if (any || call_valid) m_phase = PH_SCAN;
         PH_SCAN: begin
            if (!any) m_phase = PH_IDLE;
            else begin
               m_target = m_pick();
               m_phase  = PH_EVAL;
            end
         end
         PH_EVAL: begin
            if (car_avail == 2'b00) begin
               m_ptr   = (m_target + 1) % NF;
               m_phase = PH_SCAN;
            end else begin
               c0 = m_cost(0, m_target);
               c1 = m_cost(1, m_target);
               if (!car_avail[0])      m_car = 1;
               else if (!car_avail[1]) m_car = 0;
               else                    m_car = (c1 < c0) ? 1 : 0;
               m_phase = PH_OFFER;
            end
         end
         default: begin
            if (hs) begin
               $display("[TB] handshake car %0d floor %0d", m_car, m_target);
               m_ptr   = (m_target + 1) % NF;
               m_car   = -1;
               m_phase = PH_SCAN;
            end else if (!car_avail[m_car]) begin
               m_car   = -1;
               m_phase = PH_SCAN;
            end
         end
      endcase
   endfunction

   function automatic logic [NF-1:0] m_pend_vec();
      logic [NF-1:0] v;
      for (int f = 0; f < NF; f++) v[f] = m_pend[f];
      return v;
   endfunction

   // One clock: model follows the edge, outputs compared at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("pending", 32'(pending), 32'(m_pend_vec()));
      chk("assign_valid", 32'(assign_valid), (m_car < 0) ? 32'd0 : (32'd1 << m_car));
      chk("assign_floor", 32'(assign_floor), (m_car < 0) ? 32'd0 : (32'(m_target) << (FW * m_car)));
   endtask

   task automatic wait_offer(input string tag, input logic [1:0] ev, input logic [5:0] ef);
      int n;
      n = 0;
      while (assign_valid == 2'b00 && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(assign_valid), 32'(ev));
      chk({tag, "_floor"}, 32'(assign_floor), 32'(ef));
   endtask

   task automatic accept(input int car);
      assign_ready = 2'(1 << car);
      tick();
      assign_ready = 2'b00;
   endtask

   task automatic call(input int f);
      call_valid = 1'b1;
      call_floor = FW'(f);
      tick();
      call_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; call_valid = 1'b0; call_floor = '0;
      car_floor = '0; car_up = '0; car_down = '0; car_avail = 2'b11; assign_ready = '0;
      model_reset();
      tick(); tick();
      reset = 1'b0;
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_valid", 32'(assign_valid), 32'd0);

      // Cars at 0 and 6, call 5: car 1 is nearer.
      car_floor = {3'd6, 3'd0};
      call(5);
      chk("t1_pend", 32'(pending), 32'h20);
      tick(); tick();
      chk("t1_valid", 32'(assign_valid), 32'd2);
      chk("t1_floor", 32'(assign_floor), 32'd40);
      accept(1);
      chk("t1_clear", 32'(pending), 32'd0);

      // Car 1 at 6 going up (cost 10), car 0 at 2 (cost 2), call 4.
      tick();
      car_floor = {3'd6, 3'd2}; car_up = 2'b10;
      call(4);
      wait_offer("t2", 2'b01, 6'd4);
      accept(0);

      // Tied cars, calls 1 then 6, then 0 to exercise pointer wrap.
      car_floor = {3'd0, 3'd0}; car_up = 2'b00;
      tick(); tick();
      call(1); call(6);
      wait_offer("t3a", 2'b01, 6'd1);
      accept(0);
      wait_offer("t3b", 2'b01, 6'd6);
      accept(0);
      call(0);
      wait_offer("t3c", 2'b01, 6'd0);
      accept(0);

      // No car available: call 3 waits, then car 0 comes back.
      tick();
      car_avail = 2'b00;
      call(3);
      repeat (6) tick();
      chk("t4_novalid", 32'(assign_valid), 32'd0);
      chk("t4_pend3", 32'(pending[3]), 32'd1);
      car_avail = 2'b01;
      wait_offer("t4", 2'b01, 6'd3);
      accept(0);
      car_avail = 2'b11;

      // Re-call of the offered floor in the handshake cycle keeps it pending.
      tick();
      call(2);
      wait_offer("t5", 2'b01, 6'd2);
      call_valid = 1'b1; call_floor = 3'd2; assign_ready = 2'b01;
      tick();
      call_valid = 1'b0; assign_ready = 2'b00;
      chk("t5_pend2", 32'(pending[2]), 32'd1);
      wait_offer("t5r", 2'b01, 6'd2);
      accept(0);

`ifdef DISPATCH_AGING_EN
      // Floor 7 ages out while car 0 stalls; it beats the round-robin pick of 1.
      tick(); tick();
      call(0);
      wait_offer("t6a", 2'b01, 6'd0);
      call(7);
      repeat (16) tick();
      call(1);
      tick();
      accept(0);
      wait_offer("t6", 2'b01, 6'd7);
      accept(0);
`endif

      // Randomized traffic, including occasional mid-operation resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset        = ($urandom_range(0, 299) == 0);
         call_valid   = ($urandom_range(0, 3) == 0);
         call_floor   = FW'($urandom_range(0, NF - 1));
         car_floor    = 6'($urandom);
         car_up       = 2'($urandom);
         car_down     = 2'($urandom) & ~car_up;
         car_avail    = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
         assign_ready = 2'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
